// File: rtl/lru_pkg.sv
// rtl/lru_pkg.sv - shared tree-PLRU helpers and flush FSM state type
package lru_pkg;

    // Widest supported tree; node k of the heap lives at bit k, bit 0 unused.
    localparam int MAX_WAYS = 16;

    typedef logic [MAX_WAYS-1:0] tree_t;
    typedef logic [MAX_WAYS-1:0] way_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } flush_state_e;

    // Point every ancestor of the touched way away from it; lowest set bit wins.
    function automatic tree_t plru_next(input tree_t old_tree, input way_t way_onehot, input int ways);
        tree_t      t;
        int         w;
        int         lo;
        int         span;
        int         half;
        logic       found;
        logic [3:0] k;
        t     = old_tree;
        w     = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (!found && (i < ways) && way_onehot[i]) begin
                w     = i;
                found = 1'b1;
            end
        end
        if (found) begin
            k    = 4'd1;
            lo   = 0;
            span = ways;
            for (int l = 0; l < 4; l++) begin
                if (span > 1) begin
                    half = span / 2;
                    if (w < lo + half) begin
                        t[k] = 1'b1;
                        k    = {k[2:0], 1'b0};
                    end else begin
                        t[k] = 1'b0;
                        k    = {k[2:0], 1'b1};
                        lo   = lo + half;
                    end
                    span = half;
                end
            end
        end
        return t;
    endfunction

    // Follow node bits from the root down to a leaf: 0 goes left, 1 goes right.
    function automatic way_t plru_victim(input tree_t tree, input int ways);
        way_t       v;
        int         lo;
        int         span;
        int         half;
        logic [3:0] k;
        k    = 4'd1;
        lo   = 0;
        span = ways;
        for (int l = 0; l < 4; l++) begin
            if (span > 1) begin
                half = span / 2;
                if (tree[k]) begin
                    k  = {k[2:0], 1'b1};
                    lo = lo + half;
                end else begin
                    k  = {k[2:0], 1'b0};
                end
                span = half;
            end
        end
        v            = '0;
        v[lo[3:0]]   = 1'b1;
        return v;
    endfunction

    // One-hot of the lowest-index way whose valid bit is clear.
    function automatic way_t first_invalid(input way_t valid, input int ways);
        way_t v;
        logic found;
        v     = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (!found && (i < ways) && !valid[i]) begin
                v[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/plru_tree_next.sv
// rtl/plru_tree_next.sv - combinational single-tree touch update
module plru_tree_next
    import lru_pkg::*;
#(
    parameter int WAY_NUM = 4
) (
    input  logic [WAY_NUM-2:0] i_tree,
    input  logic [WAY_NUM-1:0] i_way,
    output logic [WAY_NUM-2:0] o_tree
);

    // Widen to the package tree layout, update, and narrow back.
    always_comb begin
        tree_t w_old;
        tree_t w_new;
        way_t  w_way;
        w_old              = '0;
        w_old[WAY_NUM-1:1] = i_tree;
        w_way              = '0;
        w_way[WAY_NUM-1:0] = i_way;
        w_new              = plru_next(w_old, w_way, WAY_NUM);
        o_tree             = w_new[WAY_NUM-1:1];
    end

endmodule

// File: rtl/plru_set_tracker.sv
// rtl/plru_set_tracker.sv - per-set tree pseudo-LRU tracker with flush sweep
module plru_set_tracker
    import lru_pkg::*;
#(
    parameter  int WAY_NUM = 4,
    parameter  int SET_NUM = 256,
    localparam int SET_W   = $clog2(SET_NUM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lookup_valid_i,
    input  logic [SET_W-1:0]   lookup_set_i,
    input  logic [WAY_NUM-1:0] way_valid_i,
    input  logic               touch_valid_i,
    input  logic [SET_W-1:0]   touch_set_i,
    input  logic [WAY_NUM-1:0] touch_way_i,
    input  logic               flush_i,
    output logic               victim_valid_o,
    output logic [WAY_NUM-1:0] victim_way_o,
    output logic               busy_o
);

    logic [WAY_NUM-2:0] r_tree [SET_NUM];
    flush_state_e       r_state;
    logic [SET_W-1:0]   r_cnt;

    logic               w_busy;
    logic               w_touch_en;
    logic               w_lookup_en;
    logic [WAY_NUM-2:0] w_touch_new;
    logic [WAY_NUM-2:0] w_lookup_tree;
    logic [WAY_NUM-1:0] w_victim;

    assign w_busy      = (r_state == SWEEP);
    assign busy_o      = w_busy;
    // A flush request in the same cycle drops the touch.
    assign w_touch_en  = touch_valid_i && !w_busy && !flush_i && (|touch_way_i);
    assign w_lookup_en = lookup_valid_i && !w_busy;

    plru_tree_next #(
        .WAY_NUM (WAY_NUM)
    ) u_tree_next (
        .i_tree (r_tree[touch_set_i]),
        .i_way  (touch_way_i),
        .o_tree (w_touch_new)
    );

    // Same-set touch is forwarded so the lookup sees the post-touch tree.
    assign w_lookup_tree = (w_touch_en && (touch_set_i == lookup_set_i)) ? w_touch_new
                                                                         : r_tree[lookup_set_i];

    // Invalid ways win over the tree; otherwise walk the tree.
    always_comb begin
        tree_t w_pad_tree;
        way_t  w_pad_valid;
        way_t  w_full;
        w_pad_tree              = '0;
        w_pad_tree[WAY_NUM-1:1] = w_lookup_tree;
        w_pad_valid             = '1;
        w_pad_valid[WAY_NUM-1:0] = way_valid_i;
        if (&way_valid_i) begin
            w_full = plru_victim(w_pad_tree, WAY_NUM);
        end else begin
            w_full = first_invalid(w_pad_valid, WAY_NUM);
        end
        w_victim = w_full[WAY_NUM-1:0];
    end

    // Flush FSM: one set cleared per cycle, counter wraps back to 0 on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush_i) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                    end
                end
                SWEEP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == SET_W'(SET_NUM - 1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tree storage: sweep clear takes precedence over touches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SET_NUM; s++) begin
                r_tree[s] <= '0;
            end
        end else if (w_busy) begin
            r_tree[r_cnt] <= '0;
        end else if (w_touch_en) begin
            r_tree[touch_set_i] <= w_touch_new;
        end
    end

    // Registered victim response; the way holds when no lookup is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_valid_o <= 1'b0;
            victim_way_o   <= '0;
        end else begin
            victim_valid_o <= w_lookup_en;
            if (w_lookup_en) begin
                victim_way_o <= w_victim;
            end
        end
    end

    a_touch_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        touch_valid_i |-> $onehot0(touch_way_i));

endmodule

// File: tb/tb_plru_set_tracker.sv
// tb/tb_plru_set_tracker.sv - scoreboard bench for plru_set_tracker
module tb_plru_set_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lookup_valid_i = 1'b0;
    logic [2:0] lookup_set_i = '0;
    logic [3:0] way_valid_i = '0;
    logic       touch_valid_i = 1'b0;
    logic [2:0] touch_set_i = '0;
    logic [3:0] touch_way_i = '0;
    logic       flush_i = 1'b0;
    logic       victim_valid_o;
    logic [3:0] victim_way_o;
    logic       busy_o;

    typedef struct {
        int         due;
        logic       v;
        logic [3:0] w;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    plru_set_tracker #(
        .WAY_NUM (4),
        .SET_NUM (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lookup_valid_i (lookup_valid_i),
        .lookup_set_i   (lookup_set_i),
        .way_valid_i    (way_valid_i),
        .touch_valid_i  (touch_valid_i),
        .touch_set_i    (touch_set_i),
        .touch_way_i    (touch_way_i),
        .flush_i        (flush_i),
        .victim_valid_o (victim_valid_o),
        .victim_way_o   (victim_way_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                total++;
                assert (victim_valid_o === e.v && victim_way_o === e.w && e.due == cyc) else begin
                    bad++;
                    $error("FAIL victim cyc=%0d due=%0d: got v=%b w=%b, exp v=%b w=%b",
                           cyc, e.due, victim_valid_o, victim_way_o, e.v, e.w);
                end
            end else begin
                total++;
                assert (victim_valid_o === 1'b0) else begin
                    bad++;
                    $error("FAIL spurious_valid cyc=%0d: got v=%b, exp v=0", cyc, victim_valid_o);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic step(input logic lv, input logic [2:0] ls, input logic [3:0] wv,
                        input logic tv, input logic [2:0] ts, input logic [3:0] tw,
                        input logic fl, input logic ev, input logic [3:0] ew);
        exp_t x;
        @(posedge clk);
        #1;
        lookup_valid_i = lv;
        lookup_set_i   = ls;
        way_valid_i    = wv;
        touch_valid_i  = tv;
        touch_set_i    = ts;
        touch_way_i    = tw;
        flush_i        = fl;
        if (lv) begin
            x.due = cyc + 1;
            x.v   = ev;
            x.w   = ew;
            q.push_back(x);
        end
    endtask

    task automatic idle();
        step(0, 0, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000);
    endtask

    task automatic look(input logic [2:0] s, input logic [3:0] wv, input logic [3:0] ew);
        step(1, s, wv, 0, 0, 4'b0000, 0, 1, ew);
    endtask

    task automatic touch(input logic [2:0] s, input logic [3:0] w);
        step(0, 0, 4'b1111, 1, s, w, 0, 0, 4'b0000);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {3'b0, victim_valid_o}, 4'b0000);
        chk("reset_way", victim_way_o, 4'b0000);
        chk("reset_busy", {3'b0, busy_o}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh tree points at way 0.
        look(3, 4'b1111, 4'b0001);
        // Training set 3.
        touch(3, 4'b0001);
        look(3, 4'b1111, 4'b0100);
        touch(3, 4'b0100);
        look(3, 4'b1111, 4'b0010);
        look(2, 4'b1111, 4'b0001);

        // Same-set forwarding and different-set independence.
        step(1, 5, 4'b1111, 1, 5, 4'b0001, 0, 1, 4'b0100);
        step(1, 7, 4'b1111, 1, 6, 4'b0001, 0, 1, 4'b0001);
        look(6, 4'b1111, 4'b0100);

        // Invalid ways take priority; lookups do not change state.
        look(3, 4'b1011, 4'b0100);
        look(3, 4'b1111, 4'b0010);
        look(3, 4'b0000, 4'b0001);
        look(3, 4'b0111, 4'b1000);

        // Deeper training on set 1 and a null touch on set 4.
        touch(1, 4'b0001);
        touch(1, 4'b0100);
        look(1, 4'b1111, 4'b0010);
        touch(1, 4'b0010);
        look(1, 4'b1111, 4'b1000);
        touch(4, 4'b0000);
        look(4, 4'b1111, 4'b0001);

        // Flush with a coincident lookup that sees pre-flush state.
        for (int s = 0; s < 8; s++) touch(3'(s), 4'b0001);
        step(1, 0, 4'b1111, 0, 0, 4'b0000, 1, 1, 4'b0100);
        @(negedge clk);
        chk("busy_flush_cycle", {3'b0, busy_o}, 4'b0000);
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) step(1, 3'(k), 4'b1111, 1, 6, 4'b0001, 1, 0, 4'b0100);
            else        step(1, 3'(k), 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0100);
            @(negedge clk);
            chk($sformatf("busy_sweep_%0d", k), {3'b0, busy_o}, 4'b0001);
        end
        look(6, 4'b1111, 4'b0001);
        @(negedge clk);
        chk("busy_after_sweep", {3'b0, busy_o}, 4'b0000);
        for (int s = 0; s < 8; s++) look(3'(s), 4'b1111, 4'b0001);

        // Reset during the 4th sweep cycle.
        touch(1, 4'b0001);
        touch(3, 4'b0001);
        touch(7, 4'b0001);
        step(0, 0, 4'b1111, 0, 0, 4'b0000, 1, 0, 4'b0000);
        repeat (4) idle();
        @(negedge clk);
        chk("busy_mid_sweep", {3'b0, busy_o}, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("busy_async_reset", {3'b0, busy_o}, 4'b0000);
        chk("valid_async_reset", {3'b0, victim_valid_o}, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        look(1, 4'b1111, 4'b0001);
        look(3, 4'b1111, 4'b0001);
        look(7, 4'b1111, 4'b0001);
        @(negedge clk);
        chk("busy_after_reset", {3'b0, busy_o}, 4'b0000);

        idle();
        idle();
        @(negedge clk);
        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain: got=%0d pending exp=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
